// File: rtl/student_fir_mc.sv
// Multi-channel time-multiplexed signed FIR: per-channel circular histories,
// one shared coefficient bank, one multiply-accumulate per cycle.
module student_fir_mc #(
    parameter int NUM_CH    = 2,
    parameter int NUM_TAPS  = 32,
    parameter int DATA_W    = 16,
    parameter int COEFF_W   = 16,
    parameter int ACC_W     = 40,
    parameter int OUT_W     = 24,
    parameter int OUT_SHIFT = 0,
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int TW = $clog2(NUM_TAPS)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CW-1:0]      in_ch,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               coeff_we,
    output logic               coeff_ready,
    input  logic [TW-1:0]      coeff_addr,
    input  logic [COEFF_W-1:0] coeff_wdata,
    output logic               out_valid,
    output logic [CW-1:0]      out_ch,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_sat,
    output logic               err_o
);

    localparam int PW      = DATA_W + COEFF_W;
    localparam int RND_POS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic signed [ACC_W:0] RND =
        (OUT_SHIFT > 0) ? ((ACC_W + 1)'(1) << RND_POS) : '0;
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t state;
    logic [TW-1:0] step_cnt;
    logic [TW-1:0] rd_ptr;
    logic [TW-1:0] wptr [NUM_CH];
    logic [CW-1:0] cur_ch;
    logic          drain_last;

    logic signed [DATA_W-1:0]  hist  [NUM_CH][NUM_TAPS];
    logic signed [COEFF_W-1:0] coeff [NUM_TAPS];

    logic signed [DATA_W-1:0]  x_q;
    logic signed [COEFF_W-1:0] h_q;
    logic                      rd_vld;
    logic signed [PW-1:0]      prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   acc;

    logic accept;
    logic ch_ok;
    logic hist_we;
    logic coeff_wr;

    logic signed [ACC_W:0]   acc_ext;
    logic signed [ACC_W:0]   rounded;
    logic signed [ACC_W:0]   shifted;
    logic [OUT_W-1:0]        res_data;
    logic                    res_sat;

    assign accept   = in_valid & in_ready;
    assign ch_ok    = ({1'b0, in_ch} < (CW + 1)'(NUM_CH));
    assign hist_we  = accept & ch_ok;
    assign coeff_wr = coeff_we & coeff_ready;

    assign prod     = x_q * h_q;
    assign prod_ext = {{(ACC_W - PW){prod[PW-1]}}, prod};

    // Round half up, arithmetic shift, then clip to the signed output range.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' and assigns every output a default first, so no latch can be inferred.
        res_data = '0;
        res_sat  = 1'b0;
        acc_ext  = {acc[ACC_W-1], acc};
        rounded  = acc_ext + RND;
        shifted  = rounded >>> OUT_SHIFT;
        if (shifted > SAT_MAX) begin
            res_data = SAT_MAX[OUT_W-1:0];
            res_sat  = 1'b1;
        end else if (shifted < SAT_MIN) begin
            res_data = SAT_MIN[OUT_W-1:0];
            res_sat  = 1'b1;
        end else begin
            res_data = shifted[OUT_W-1:0];
        end
    end

    // NOTE: the storage arrays have no reset; they are zeroed by the CLEAR walk instead, which keeps them mappable to RAM.
    always_ff @(posedge clk_i) begin
        if (state == S_CLEAR) begin
            for (int c = 0; c < NUM_CH; c++) begin
                hist[c][step_cnt] <= '0;
            end
            coeff[step_cnt] <= '0;
        end else begin
            if (hist_we) begin
                hist[in_ch][wptr[in_ch]] <= in_data;
            end
            if (coeff_wr) begin
                coeff[coeff_addr] <= coeff_wdata;
            end
        end
    end

    // NOTE: sequential state is updated only with non-blocking '<=' so every register sees pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_CLEAR;
            step_cnt    <= '0;
            rd_ptr      <= '0;
            cur_ch      <= '0;
            drain_last  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                wptr[c] <= '0;
            end
            x_q         <= '0;
            h_q         <= '0;
            rd_vld      <= 1'b0;
            acc         <= '0;
            in_ready    <= 1'b0;
            coeff_ready <= 1'b0;
            out_valid   <= 1'b0;
            out_ch      <= '0;
            out_data    <= '0;
            out_sat     <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            err_o     <= 1'b0;
            rd_vld    <= 1'b0;
            if (rd_vld) begin
                acc <= acc + prod_ext;
            end

            case (state)
                S_CLEAR: begin
                    if (step_cnt == TW'(NUM_TAPS - 1)) begin
                        step_cnt    <= '0;
                        state       <= S_IDLE;
                        in_ready    <= 1'b1;
                        coeff_ready <= 1'b1;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end

                S_IDLE: begin
                    if (accept) begin
                        if (ch_ok) begin
                            state         <= S_MAC;
                            in_ready      <= 1'b0;
                            coeff_ready   <= 1'b0;
                            cur_ch        <= in_ch;
                            rd_ptr        <= wptr[in_ch];
                            wptr[in_ch]   <= wptr[in_ch] + 1'b1;
                            step_cnt      <= '0;
                            acc           <= '0;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end

                // Tap k reads the sample written k acceptances ago, newest first.
                S_MAC: begin
                    x_q      <= hist[cur_ch][rd_ptr];
                    h_q      <= coeff[step_cnt];
                    rd_vld   <= 1'b1;
                    rd_ptr   <= rd_ptr - 1'b1;
                    step_cnt <= step_cnt + 1'b1;
                    if (step_cnt == TW'(NUM_TAPS - 1)) begin
                        state      <= S_DRAIN;
                        drain_last <= 1'b0;
                    end
                end

                S_DRAIN: begin
                    if (drain_last) begin
                        state     <= S_OUT;
                        out_valid <= 1'b1;
                        out_ch    <= cur_ch;
                        out_data  <= res_data;
                        out_sat   <= res_sat;
                    end else begin
                        drain_last <= 1'b1;
                    end
                end

                S_OUT: begin
                    state       <= S_IDLE;
                    in_ready    <= 1'b1;
                    coeff_ready <= 1'b1;
                end

                default: state <= S_CLEAR;
            endcase
        end
    end

endmodule
